mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the core's peripheral bus, directly downstream of the pipeline datapath's M stage.
- Consumes m_addr, m_data, m_rnw and m_sel, and returns read data on s_data in the same cycle for the M-stage write-back mux.
- Buffers bytes in a TX FIFO and serialises them as 8N1 frames on a baud-rate counter.

---
 rtl/mmio_uart_tx.sv | 218 +++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO and programmable baud divider.
// Define UART_TX_IRQ_EN to build the registered "FIFO drained" interrupt and CTRL[1].
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_data,
    input  logic        m_rnw,
    input  logic        m_sel,
    output logic [31:0] s_data,
    output logic        tx,
    output logic        irq
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic             hit;
    logic             wr_en;
    logic [1:0]       reg_idx;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             busy;
    logic [15:0]      div_m1;
    logic [31:0]      count_ext;
    logic [31:0]      ctrl_rd;
    logic             unused_bits;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             overflow_reg;
    logic [15:0]      div_reg;
    logic             enable_reg;

    state_t           state_reg, state_next;
    logic [15:0]      baud_cnt_reg, baud_cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;

    assign hit      = m_sel & (m_addr[31:4] == BASE_ADDR[31:4]);
    assign wr_en    = hit & ~m_rnw;
    assign reg_idx  = m_addr[3:2];
    assign count_ext = 32'(count_reg);
    assign unused_bits = ^{m_addr[1:0], m_data[31:16], count_ext[31:4]};

    assign full     = (count_reg == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_reg == '0);
    assign pop      = (state_reg == S_IDLE) & enable_reg & ~empty;
    assign push_req = wr_en & (reg_idx == 2'd0);
    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign push     = push_req & (~full | pop);

    // A divider of 0 behaves as 1, so the reload value saturates at 0.
    assign div_m1   = (div_reg == 16'd0) ? 16'd0 : div_reg - 16'd1;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= m_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CNT_W'(1);
            end
            if (push_req && full && !pop) begin
                overflow_reg <= 1'b1;
            end else if (wr_en && reg_idx == 2'd1 && m_data[3]) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg    <= DEFAULT_DIV;
            enable_reg <= 1'b0;
        end else if (wr_en) begin
            if (reg_idx == 2'd2) begin
                div_reg <= m_data[15:0];
            end
            if (reg_idx == 2'd3) begin
                enable_reg <= m_data[0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_idx_reg  <= bit_idx_next;
            shift_reg    <= shift_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_idx_next  = bit_idx_reg;
        shift_next    = shift_reg;
        case (state_reg)
            S_IDLE: begin
                if (pop) begin
                    shift_next    = fifo_mem[rd_ptr_reg];
                    baud_cnt_next = div_m1;
                    state_next    = S_START;
                end
            end
            S_START: begin
                if (baud_cnt_reg == 16'd0) begin
                    baud_cnt_next = div_m1;
                    bit_idx_next  = 3'd0;
                    state_next    = S_DATA;
                end else begin
                    baud_cnt_next = baud_cnt_reg - 16'd1;
                end
            end
            S_DATA: begin
                if (baud_cnt_reg == 16'd0) begin
                    baud_cnt_next = div_m1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = S_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        shift_next   = shift_reg >> 1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg - 16'd1;
                end
            end
            S_STOP: begin
                if (baud_cnt_reg == 16'd0) begin
                    state_next = S_IDLE;
                end else begin
                    baud_cnt_next = baud_cnt_reg - 16'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Line level is decoded from state so reset drives tx high without waiting for a clock.
    always_comb begin
        tx   = 1'b1;
        busy = 1'b1;
        case (state_reg)
            S_IDLE:  busy = 1'b0;
            S_START: tx   = 1'b0;
            S_DATA:  tx   = shift_reg[0];
            default: tx   = 1'b1;
        endcase
    end

`ifdef UART_TX_IRQ_EN
    logic irq_en_reg;
    logic irq_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_reg <= 1'b0;
            irq_reg    <= 1'b0;
        end else begin
            if (wr_en && reg_idx == 2'd3) begin
                irq_en_reg <= m_data[1];
            end
            irq_reg <= irq_en_reg & empty & ~busy;
        end
    end

    assign irq     = irq_reg;
    assign ctrl_rd = {30'd0, irq_en_reg, enable_reg};
`else
    assign irq     = 1'b0;
    assign ctrl_rd = {31'd0, enable_reg};
`endif

    always_comb begin
        s_data = '0;
        if (hit && m_rnw) begin
            case (reg_idx)
                2'd1:    s_data = {24'd0, count_ext[3:0], overflow_reg, empty, full, busy};
                2'd2:    s_data = {16'd0, div_reg};
                2'd3:    s_data = ctrl_rd;
                default: s_data = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: bytes accepted by the bus model are queued and
// a serial-line receiver pops and compares each 8N1 frame it decodes from tx.
`timescale 1ns/1ps
module tb_mmio_uart_tx;
    localparam logic [31:0] A_TXDATA = 32'h0000_1000;
    localparam logic [31:0] A_STATUS = 32'h0000_1004;
    localparam logic [31:0] A_DIV    = 32'h0000_1008;
    localparam logic [31:0] A_CTRL   = 32'h0000_100C;
    localparam int          DEPTH    = 8;
    localparam int          LIMIT    = 20000;
`ifdef UART_TX_IRQ_EN
    localparam logic [31:0] CTRL_MASK = 32'h3;
`else
    localparam logic [31:0] CTRL_MASK = 32'h1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_data = '0;
    logic        m_rnw = 1'b1;
    logic        m_sel = 1'b0;
    logic [31:0] s_data;
    logic        tx;
    logic        irq;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int cur_div = 868;
    bit mon_en = 1'b1;
    int prev_start = 0, last_start = 0, last_end = 0;
    int frame_cnt = 0, tot_pushed = 0;
    logic [7:0]  sb[$];
    logic [31:0] mdl_div = 32'd868;
    logic [31:0] mdl_ctrl = 32'd0;

    mmio_uart_tx #(
        .BASE_ADDR(32'h0000_1000), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd868)
    ) dut (
        .clk(clk), .rst_n(rst_n), .m_addr(m_addr), .m_data(m_data),
        .m_rnw(m_rnw), .m_sel(m_sel), .s_data(s_data), .tx(tx), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d, input logic sel);
        m_sel = sel; m_rnw = 1'b0; m_addr = a; m_data = d;
        @(posedge clk); #1;
        m_sel = 1'b0; m_rnw = 1'b1; m_addr = '0; m_data = '0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus_xfer(a, d, 1'b1);
        $display("write addr=0x%08h data=0x%08h", a, d);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        m_sel = 1'b1; m_rnw = 1'b1; m_addr = a;
        #1 d = s_data;
        m_sel = 1'b0; m_addr = '0;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus_write(A_TXDATA, {24'd0, b});
        sb.push_back(b);
        tot_pushed++;
    endtask

    task automatic set_div(input logic [15:0] dv);
        bus_write(A_DIV, {16'd0, dv});
        mdl_div = {16'd0, dv};
        cur_div = (dv == 16'd0) ? 1 : int'(dv);
    endtask

    task automatic set_ctrl(input logic [31:0] c);
        bus_write(A_CTRL, c);
        mdl_ctrl = c & CTRL_MASK;
    endtask

    task automatic wait_idle(input string name);
        logic [31:0] st;
        int n;
        bit done;
        n = 0; done = 1'b0;
        while (!done && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
            if (sb.size() == 0) begin
                bus_read(A_STATUS, st);
                done = (st[0] == 1'b0) && (st[2] == 1'b1);
            end
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    // Serial receiver: every bit must hold for exactly cur_div samples.
    initial begin : monitor
        logic [9:0] bits;
        int d, st;
        bit steady;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && tx === 1'b0) begin
                d = cur_div; st = cyc; steady = 1'b1; bits = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int s = 0; s < d; s++) begin
                        if (b != 0 || s != 0) @(negedge clk);
                        if (s == 0) bits[b] = tx;
                        else if (tx !== bits[b]) steady = 1'b0;
                    end
                end
                prev_start = last_start; last_start = st; last_end = cyc;
                frame_cnt++;
                $display("frame data=0x%02h start_cyc=%0d div=%0d", bits[8:1], st, d);
                check("frame_bit_width", {31'd0, steady}, 32'd1);
                check("frame_stop", {31'd0, bits[9]}, 32'd1);
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL frame_unexpected: got 0x%02h expected no frame", bits[8:1]);
                end else begin
                    logic [7:0] exp;
                    exp = sb.pop_front();
                    checks--;
                    check("frame_data", {24'd0, bits[8:1]}, {24'd0, exp});
                end
            end
        end
    end

    initial begin : stim
        logic [31:0] st;
        int n, n_low, op;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        read_check("rst_status", A_STATUS, 32'h0000_0004);
        read_check("rst_div", A_DIV, 32'd868);
        read_check("rst_ctrl", A_CTRL, 32'd0);
        read_check("rst_txdata_rd", A_TXDATA, 32'd0);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd0);

        // Single frame at div 4
        set_div(16'd4);
        set_ctrl(32'd1);
        push_byte(8'hA5);
        check("tx_before_pop", {31'd0, tx}, 32'd1);
        @(posedge clk); #1;
        check("tx_start_low", {31'd0, tx}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            bus_read(A_STATUS, st);
            check("busy_in_frame", {31'd0, st[0]}, 32'd1);
            repeat (3) @(posedge clk);
            #1;
        end
        wait_idle("idle_after_a5");

        // Overflow with the transmitter disabled
        set_ctrl(32'd0);
        for (int i = 0; i < 8; i++) push_byte(8'(8'h30 + i));
        bus_write(A_TXDATA, 32'h0000_00EE);
        read_check("status_overflow", A_STATUS, 32'h0000_008A);
        bus_write(A_STATUS, 32'd8);
        read_check("status_ovf_clear", A_STATUS, 32'h0000_0082);
        set_div(16'd1);
        set_ctrl(32'd1);
        wait_idle("idle_after_drain");

        // BAUDDIV = 0 behaves as 1, back-to-back frames
        set_ctrl(32'd0);
        set_div(16'd0);
        read_check("div_zero_rd", A_DIV, 32'd0);
        push_byte(8'h96);
        push_byte(8'h3C);
        set_ctrl(32'd1);
        wait_idle("idle_after_b2b");
        check("b2b_gap", 32'(last_start - prev_start), 32'd11);
        check("b2b_total", 32'(last_end - prev_start + 1), 32'd21);

`ifdef UART_TX_IRQ_EN
        set_div(16'd2);
        set_ctrl(32'd3);
        push_byte(8'h5A);
        @(posedge clk); #1;
        check("irq_low_busy", {31'd0, irq}, 32'd0);
        n = 0;
        while (n < 200) begin
            @(posedge clk); #1;
            n++;
            bus_read(A_STATUS, st);
            if (st[0] == 1'b0) break;
            check("irq_low_busy", {31'd0, irq}, 32'd0);
        end
        check("irq_idle_timeout", {31'd0, (n < 200)}, 32'd1);
        check("irq_first_idle", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        check("irq_set", {31'd0, irq}, 32'd1);
`else
        set_ctrl(32'd3);
        read_check("ctrl_no_irq_bit", A_CTRL, 32'd1);
        repeat (3) @(posedge clk);
        #1 check("irq_tied", {31'd0, irq}, 32'd0);
`endif

        // Decode: deselected or foreign addresses neither read nor write
        m_sel = 1'b0; m_rnw = 1'b1; m_addr = A_DIV;
        #1 check("nosel_read", s_data, 32'd0);
        m_addr = '0;
        read_check("foreign_read", 32'h0000_2008, 32'd0);
        bus_write(32'h0000_200C, 32'd0);
        bus_write(32'h0000_2008, 32'd77);
        bus_xfer(A_CTRL, 32'd0, 1'b0);
        bus_xfer(A_TXDATA, 32'h0000_0011, 1'b0);
        bus_write(32'h0000_2000, 32'h0000_0022);
        read_check("decode_ctrl", A_CTRL, mdl_ctrl);
        read_check("decode_div", A_DIV, mdl_div);
        read_check("decode_div_lowbits", 32'h0000_100B, mdl_div);
        repeat (30) @(posedge clk);
        #1 read_check("decode_status", A_STATUS, 32'h0000_0004);

        // Randomised traffic
        for (int r = 0; r < 3; r++) begin
            wait_idle("rand_idle");
            set_div(16'($urandom_range(0, 3)));
            set_ctrl(32'd1);
            for (int i = 0; i < 16; i++) begin
                op = int'($urandom_range(0, 5));
                if (op <= 2) begin
                    if (sb.size() < DEPTH) push_byte(8'($urandom_range(0, 255)));
                    else begin repeat (10 * cur_div) @(posedge clk); #1; end
                end else if (op == 3) begin
                    read_check("rand_div", A_DIV, mdl_div);
                    read_check("rand_ctrl", A_CTRL, mdl_ctrl);
                    bus_read(A_STATUS, st);
                    check("rand_no_ovf", {28'd0, st[31:28] | st[27:24], st[3]}, 32'd0);
                end else begin
                    repeat ($urandom_range(1, 8)) @(posedge clk);
                    #1;
                end
            end
        end
        wait_idle("rand_drain");

        // Reset in the middle of data bit 3
        mon_en = 1'b0;
        set_div(16'd4);
        set_ctrl(32'd1);
        bus_write(A_TXDATA, 32'h0000_0037);
        repeat (17) @(posedge clk);
        #3 check("tx_bit3_low", {31'd0, tx}, 32'd0);
        rst_n = 1'b0;
        #1 check("tx_async_reset", {31'd0, tx}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        mdl_div = 32'd868; mdl_ctrl = 32'd0; cur_div = 868;
        @(posedge clk); #1;
        read_check("post_rst_status", A_STATUS, 32'h0000_0004);
        read_check("post_rst_ctrl", A_CTRL, 32'd0);
        read_check("post_rst_div", A_DIV, 32'd868);
        n_low = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) n_low++;
        end
        check("post_rst_no_frame", 32'(n_low), 32'd0);
        mon_en = 1'b1;

        check("sb_empty", 32'(sb.size()), 32'd0);
        check("frames_total", 32'(frame_cnt), 32'(tot_pushed));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
